// File: rtl/uart_byte_fifo.sv
// uart_byte_fifo: FWFT byte FIFO behind the UART receiver with fill level, almost-full and sticky overflow.
module uart_byte_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AFULL_LEVEL = DEPTH - 2,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  almost_full,
  output logic                  overflow,
  input  logic                  ovf_clr
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic push, pop;
  always_comb begin
    full        = count == (ADDR_WIDTH+1)'(DEPTH);
    almost_full = count >= (ADDR_WIDTH+1)'(AFULL_LEVEL);
    rd_valid    = count != '0;
    rd_data     = mem[rd_ptr];
    push        = wr_en & ~full;
    pop         = rd_valid & rd_ready;
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wr_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count    <= push & ~pop ? count + 1'b1 : pop & ~push ? count - 1'b1 : count;
      overflow <= wr_en & full ? 1'b1 : ovf_clr ? 1'b0 : overflow;
    end
endmodule

// File: tb/tb_uart_byte_fifo.sv
// tb_uart_byte_fifo: directed and random stimulus against a queue-based model of the FIFO.
module tb_uart_byte_fifo;
  logic       clk = 1'b0;
  logic       rst_n, wr_en, rd_ready, ovf_clr;
  logic [7:0] wr_data, rd_data;
  logic       rd_valid, full, almost_full, overflow;
  logic [4:0] count;
  logic [7:0] q[$];
  logic       m_ovf;
  int         n_checks = 0, n_fail = 0;
  always #5 clk = ~clk;
  uart_byte_fifo dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .count(count), .full(full), .almost_full(almost_full),
    .overflow(overflow), .ovf_clr(ovf_clr)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_state();
    check("count", 32'(count), 32'(q.size()));
    check("rd_valid", 32'(rd_valid), 32'(q.size() != 0));
    check("full", 32'(full), 32'(q.size() == 16));
    check("almost_full", 32'(almost_full), 32'(q.size() >= 14));
    check("overflow", 32'(overflow), 32'(m_ovf));
    if (q.size() != 0) check("rd_data", 32'(rd_data), 32'(q[0]));
  endtask
  task automatic step(input logic we, input logic [7:0] wd, input logic rr, input logic clr);
    bit do_push, do_pop;
    wr_en = we; wr_data = wd; rd_ready = rr; ovf_clr = clr;
    @(negedge clk);
    check_state();
    do_push = we && q.size() < 16;
    do_pop  = rr && q.size() != 0;
    m_ovf = (we && q.size() == 16) ? 1'b1 : clr ? 1'b0 : m_ovf;
    if (do_pop) void'(q.pop_front());
    if (do_push) q.push_back(wd);
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; rd_ready = 1'b0; ovf_clr = 1'b0;
    m_ovf = 1'b0;
    #1;
    check_state();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step(1, 8'hA5, 0, 0);
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 1, 0);
    for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0);
    step(1, 8'hEE, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 8'h00, 1, 0);
    for (int i = 0; i < 40; i++) begin
      step(1, 8'(8'h10 + i), 0, 0);
      step(0, 8'h00, 1, 0);
    end
    step(0, 8'h00, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 8'(8'h40 + i), 0, 0);
    step(1, 8'h55, 1, 0);
    for (int i = 0; i < 11; i++) step(1, 8'(8'h60 + i), 0, 0);
    step(1, 8'hDD, 1, 0);
    step(1, 8'h77, 0, 0);
    step(0, 8'h00, 0, 1);
    step(1, 8'hCC, 0, 1);
    step(0, 8'h00, 0, 0);
    while (q.size() > 7) step(0, 8'h00, 1, 0);
    #2 rst_n = 1'b0;
    q.delete();
    m_ovf = 1'b0;
    #1;
    check_state();
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1, 8'h3C, 0, 0);
    step(0, 8'h00, 1, 0);
    for (int p = 0; p < 6; p++) begin
      int wp, rp;
      wp = (p % 3 == 0) ? 80 : (p % 3 == 1) ? 50 : 20;
      rp = 100 - wp;
      for (int i = 0; i < 300; i++)
        step($urandom_range(99) < wp, 8'($urandom), $urandom_range(99) < rp, $urandom_range(15) == 0);
    end
    step(0, 8'h00, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_byte_fifo.md
Name: uart_byte_fifo

Overview:
- Synchronous first-word-fall-through (FWFT) FIFO placed directly downstream of the UART receiver.
- Captures each received byte on the receiver's one-cycle `done` strobe.
- Presents buffered bytes to the next stage (AXI write packer toward DDR) via a valid/ready interface.
- Tracks fill level and reports an almost-full warning; a sticky overflow flag records bytes dropped while full.

Parameters:
- DATA_WIDTH, 8, byte width; matches the receiver's `result` width.
- DEPTH, 16, number of entries; must be a power of two, minimum 2.
- ADDR_WIDTH, $clog2(DEPTH), pointer width; derived, not overridden.
- AFULL_LEVEL, DEPTH-2, `count` at or above which `almost_full` asserts.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- wr_en  input  1  write strobe; driven by the receiver's `done`, a one-cycle pulse.
- wr_data  input  DATA_WIDTH  byte to store; driven by the receiver's `result`.
- rd_data  output  DATA_WIDTH  head-of-queue byte; valid only while `rd_valid`=1.
- rd_valid  output  1  FIFO non-empty; head byte is presented.
- rd_ready  input  1  consumer accepts the head byte this cycle.
- count  output  ADDR_WIDTH+1  number of stored entries, 0..DEPTH.
- full  output  1  count==DEPTH.
- almost_full  output  1  count>=AFULL_LEVEL.
- overflow  output  1  sticky: a write was dropped because the FIFO was full.
- ovf_clr  input  1  synchronous clear for `overflow`.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - wr_ptr=0, rd_ptr=0, count=0, overflow=0.
  - Hence rd_valid=0, full=0, almost_full=0.
  - rd_data is don't-care; storage contents are not reset.
  - Reset asserted mid-operation discards all stored bytes immediately; no partial state survives.
- Push: a push occurs when wr_en=1 and full=0.
  - At the clock edge, wr_data is stored at mem[wr_ptr].
  - wr_ptr advances by 1 modulo DEPTH (natural wrap at ADDR_WIDTH bits).
- Pop: a pop occurs when rd_valid=1 and rd_ready=1.
  - At the clock edge, rd_ptr advances by 1 modulo DEPTH.
- FWFT timing:
  - rd_data = mem[rd_ptr], combinational from storage.
  - rd_valid = (count!=0).
  - A byte pushed at edge N is visible on rd_data with rd_valid=1 in the cycle after edge N. Write-to-read latency is 1 cycle.
- Count update (registered):
  - Push only: +1.
  - Pop only: -1.
  - Push and pop together: unchanged.
  - Neither: unchanged.
- full, almost_full and rd_valid are decoded combinationally from the registered count. They change only on clock edges or reset.
- Empty with wr_en=1 and rd_ready=1: push accepted, no pop (rd_valid=0). count becomes 1.
- Full with wr_en=1:
  - Write is dropped and memory is unchanged, even if a pop occurs the same cycle. No write-through when full.
  - overflow is set at that edge.
  - A pop in the same cycle still proceeds, so count goes DEPTH -> DEPTH-1.
- Overflow flag:
  - Once set, overflow holds until ovf_clr=1 at a clock edge.
  - If ovf_clr=1 and a new dropped write occur in the same cycle, overflow stays 1 (set wins).
- rd_ready=1 while rd_valid=0 has no effect.
- wr_en held high for multiple cycles pushes once per cycle. The receiver normally pulses it once per byte.
- Pointers and count never exceed their ranges; count never exceeds DEPTH and never underflows below 0.
- Sizing: the receiver produces at most one byte per ~10 bit times, so DEPTH=16 absorbs consumer stalls of about 160 bit times without loss.

Test Plan:
- Reset and single byte:
  - Stimulus: reset; pulse wr_en once with wr_data=0xA5 at edge N.
  - Required response: rd_valid=1 and rd_data=0xA5 from edge N; count=1.
  - Then set rd_ready=1 for one cycle: rd_valid=0, count=0.
- Fill to full:
  - Stimulus: rd_ready=0; push 0x00..0x0F (16 bytes).
  - Required response: almost_full=1 after the 14th push; full=1 and count=16 after the 16th.
  - Then push 0xEE: overflow=1, count stays 16.
  - Then drain 16 bytes: reads 0x00..0x0F in order; 0xEE never appears.
- Wrap-around:
  - Stimulus: 40 bytes (0x10..0x37) with alternating push and pop.
  - Required response: output sequence equals input sequence; count never exceeds 2; pointers wrap with no errors.
- Simultaneous push and pop:
  - Stimulus: at count=5, wr_en=1 and rd_ready=1 together.
  - Required response: count stays 5; head advances; new byte lands at the tail.
  - Stimulus: at count=16, wr_en=1 and rd_ready=1 together.
  - Required response: count=15; overflow=1; dropped byte is absent.
- Overflow clear priority:
  - Stimulus: with overflow=1, assert ovf_clr alone.
  - Required response: overflow=0.
  - Stimulus: with the FIFO full, assert ovf_clr and wr_en in the same cycle.
  - Required response: overflow=1.
- Asynchronous reset mid-stream:
  - Stimulus: with count=7, drop rst_n between clock edges.
  - Required response: count=0, rd_valid=0, overflow=0 immediately, without waiting for a clock edge.
  - After release, the next push of 0x3C reads back 0x3C.
